// File: rtl/lab2_proc_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function
// encoding, FSM state encoding and small fn-decoding helpers.
package lab2_proc_muldiv_pkg;

    typedef enum logic [2:0] {
        FN_MUL    = 3'd0,
        FN_MULH   = 3'd1,
        FN_MULHSU = 3'd2,
        FN_MULHU  = 3'd3,
        FN_DIV    = 3'd4,
        FN_DIVU   = 3'd5,
        FN_REM    = 3'd6,
        FN_REMU   = 3'd7
    } fn_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper encoding bit selects the divider
    function automatic logic fn_is_div(input logic [2:0] fn);
        return fn[2];
    endfunction

    // REM/REMU return the remainder instead of the quotient
    function automatic logic fn_is_rem(input logic [2:0] fn);
        return fn[2] && fn[1];
    endfunction

    // Operand a is treated as two's complement
    function automatic logic fn_a_signed(input logic [2:0] fn);
        return (fn == FN_MULH) || (fn == FN_MULHSU) ||
               (fn == FN_DIV)  || (fn == FN_REM);
    endfunction

    // Operand b is treated as two's complement
    function automatic logic fn_b_signed(input logic [2:0] fn);
        return (fn == FN_MULH) || (fn == FN_DIV) || (fn == FN_REM);
    endfunction

    // Multiplies that return the upper half of the product
    function automatic logic fn_hi_half(input logic [2:0] fn);
        return !fn[2] && (fn[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/lab2_proc_iter_muldiv_dpath.sv
// Datapath of the iterative multiply/divide unit: shift-add multiplier on a
// double-width accumulator, restoring divider, iteration counter and the
// final sign fix. Optional early termination of multiplies is enabled by
// defining LAB2_PROC_MULDIV_EARLY_TERM_EN.
module lab2_proc_iter_muldiv_dpath
    import lab2_proc_muldiv_pkg::*;
#(
    parameter int p_nbits = 32
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [2:0]         fn,
    input  logic [p_nbits-1:0] a,
    input  logic [p_nbits-1:0] b,
    output logic               last,
    output logic [p_nbits-1:0] result
);

    localparam int p_cntbits = $clog2(p_nbits) + 1;
    localparam int p_wbits   = 2 * p_nbits;

    // Magnitude of an operand, negating only when it is signed and negative
    function automatic logic [p_nbits-1:0] mag(input logic [p_nbits-1:0] v,
                                               input logic               sgn);
        return (sgn && v[p_nbits-1]) ? (~v + 1'b1) : v;
    endfunction

    // Sign fix of the full double-width product
    function automatic logic [p_wbits-1:0] fix_wide(input logic [p_wbits-1:0] v,
                                                    input logic               neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Sign fix of a quotient or remainder
    function automatic logic [p_nbits-1:0] fix_narrow(input logic [p_nbits-1:0] v,
                                                      input logic               neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [2:0]           fn_r;
    logic                 neg_r;
    logic [p_cntbits-1:0] cnt;
    logic [p_wbits-1:0]   acc;    // product accumulator, or remainder in the low half
    logic [p_wbits-1:0]   a_sh;   // shifted multiplicand, or dividend/quotient in the low half
    logic [p_nbits-1:0]   b_sh;   // remaining multiplier magnitude, or divisor

    logic                 ld_a_neg, ld_b_neg, ld_b_zero, ld_neg;
    logic                 is_div;
    logic [p_wbits-1:0]   acc_n;
    logic [p_nbits-1:0]   b_sh_n;
    logic [p_nbits:0]     rem_sh, diff;
    logic                 ge;
    logic [p_nbits-1:0]   rem_n, quo_n;
    logic [p_wbits-1:0]   acc_step, a_step, prod_fix;
    logic [p_nbits-1:0]   b_step, div_val, res_fix;

    // Result sign decided at acceptance; a zero divisor forces an all-ones quotient
    always_comb begin
        ld_a_neg  = fn_a_signed(fn) && a[p_nbits-1];
        ld_b_neg  = fn_b_signed(fn) && b[p_nbits-1];
        ld_b_zero = (b == '0);
        if (fn_is_div(fn)) begin
            ld_neg = fn_is_rem(fn) ? ld_a_neg : ((ld_a_neg ^ ld_b_neg) && !ld_b_zero);
        end else begin
            ld_neg = ld_a_neg ^ ld_b_neg;
        end
    end

    // One multiply or divide iteration plus the sign-fixed final result
    always_comb begin
        is_div  = fn_is_div(fn_r);
        acc_n   = b_sh[0] ? (acc + a_sh) : acc;
        b_sh_n  = b_sh >> 1;
        rem_sh  = {acc[p_nbits-1:0], a_sh[p_nbits-1]};
        diff    = rem_sh - {1'b0, b_sh};
        ge      = !diff[p_nbits];
        rem_n   = ge ? diff[p_nbits-1:0] : rem_sh[p_nbits-1:0];
        quo_n   = {a_sh[p_nbits-2:0], ge};

        acc_step = is_div ? {{p_nbits{1'b0}}, rem_n} : acc_n;
        a_step   = is_div ? {{p_nbits{1'b0}}, quo_n} : (a_sh << 1);
        b_step   = is_div ? b_sh : b_sh_n;

        prod_fix = fix_wide(acc_n, neg_r);
        div_val  = fn_is_rem(fn_r) ? rem_n : quo_n;
        if (is_div) begin
            res_fix = fix_narrow(div_val, neg_r);
        end else if (fn_hi_half(fn_r)) begin
            res_fix = prod_fix[p_wbits-1:p_nbits];
        end else begin
            res_fix = prod_fix[p_nbits-1:0];
        end
    end

`ifdef LAB2_PROC_MULDIV_EARLY_TERM_EN
    assign last = (cnt == p_cntbits'(1)) || (!is_div && (b_sh_n == '0));
`else
    assign last = (cnt == p_cntbits'(1));
`endif

    // Operand load at acceptance, then one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            fn_r   <= '0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
        end else if (load) begin
            fn_r  <= fn;
            neg_r <= ld_neg;
            cnt   <= p_cntbits'(p_nbits);
            acc   <= '0;
            a_sh  <= {{p_nbits{1'b0}}, mag(a, fn_a_signed(fn))};
            b_sh  <= mag(b, fn_b_signed(fn));
        end else if (step) begin
            cnt  <= cnt - p_cntbits'(1);
            acc  <= acc_step;
            a_sh <= a_step;
            b_sh <= b_step;
            if (last) begin
                result <= res_fix;
            end
        end
    end

endmodule

// File: rtl/lab2_proc_iter_muldiv.sv
// Iterative RV32M-style multiply/divide unit with val/rdy request and
// response handshakes. Holds the IDLE/CALC/DONE FSM; arithmetic lives in
// lab2_proc_iter_muldiv_dpath. Defining LAB2_PROC_MULDIV_EARLY_TERM_EN lets
// multiplies finish as soon as the remaining multiplier is exhausted.
module lab2_proc_iter_muldiv
    import lab2_proc_muldiv_pkg::*;
#(
    parameter int p_nbits = 32
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2:0]         req_fn,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_data
);

    state_t             state;
    logic               load;
    logic               step;
    logic               last;
    logic [p_nbits-1:0] result;

    // Handshake outputs decode the registered state and are forced low during reset
    assign req_rdy   = (state == IDLE) && !reset;
    assign resp_val  = (state == DONE) && !reset;
    assign resp_data = reset ? '0 : result;
    assign load      = req_val && req_rdy;
    assign step      = (state == CALC);

    // Control FSM: accept, iterate until the datapath flags the last step, hold result
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (req_val) state <= CALC;
                CALC:    if (last)    state <= DONE;
                DONE:    if (resp_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    lab2_proc_iter_muldiv_dpath #(
        .p_nbits (p_nbits)
    ) u_dpath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .fn     (req_fn),
        .a      (req_a),
        .b      (req_b),
        .last   (last),
        .result (result)
    );

endmodule
